// File: rtl/bin_to_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock),
// latency: result valid WIDTH cycles after the accept edge, II = WIDTH+2 cycles,
// backpressure: holds result and keeps in_ready low until out_ready is seen.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready high only when idle
//   d_input [WIDTH]       binary word, unsigned or two's complement (SIGNED)
//   out_valid / out_ready output handshake; result held while out_valid
//   d_out [4*DIGITS]      packed BCD, digit 0 (units) in bits [3:0]
//   neg                   input was negative (always 0 when SIGNED=0)
//   overflow              magnitude did not fit; d_out saturated to all 9s
module bin_to_bcd_conv #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter bit SIGNED = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    d_input,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] d_out,
   output logic                neg,
   output logic                overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mag;
   logic [BW-1:0]    bcd;
   logic [CW-1:0]    bit_cnt;
   logic             ovf_acc;
   logic             neg_acc;

   logic             in_neg;
   logic [WIDTH-1:0] in_mag;
   logic [BW-1:0]    bcd_adj;
   logic [BW-1:0]    bcd_nxt;
   logic             ovf_nxt;

   // Magnitude of the incoming word. Negating -2^(WIDTH-1) in WIDTH bits
   // yields the same bit pattern, which read as unsigned is the right value.
   always_comb begin
      in_neg = SIGNED && d_input[WIDTH-1];
      in_mag = in_neg ? (~d_input + WIDTH'(1)) : d_input;
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift the next
   // magnitude bit in. Whatever leaves the top digit means the value no
   // longer fits in DIGITS digits.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      bcd_nxt = {bcd_adj[BW-2:0], mag[WIDTH-1]};
      ovf_nxt = ovf_acc | bcd_adj[BW-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         d_out     <= '0;
         neg       <= 1'b0;
         overflow  <= 1'b0;
         mag       <= '0;
         bcd       <= '0;
         bit_cnt   <= '0;
         ovf_acc   <= 1'b0;
         neg_acc   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mag      <= in_mag;
                  neg_acc  <= in_neg;
                  bcd      <= '0;
                  bit_cnt  <= '0;
                  ovf_acc  <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end

            SHIFT: begin
               bcd     <= bcd_nxt;
               mag     <= {mag[WIDTH-2:0], 1'b0};
               ovf_acc <= ovf_nxt;
               // bit_cnt ends at WIDTH, which fits in CW bits, so it never wraps.
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == LAST_BIT) begin
                  // Final step: publish the result from this step's values.
                  state     <= DONE;
                  out_valid <= 1'b1;
                  d_out     <= ovf_nxt ? ALL_NINES : bcd_nxt;
                  neg       <= neg_acc;
                  overflow  <= ovf_nxt;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Bench for bin_to_bcd_conv: three instances (unsigned/5 digits, signed/5 digits,
// unsigned/4 digits) driven one at a time; results checked from a scoreboard,
// backpressure exercised by holding out_ready low on the unsigned instance.
module tb_bin_to_bcd_conv;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]  in_valid, in_ready, out_valid, out_ready, neg, ovf;
   logic [15:0] d_in [3];
   logic [19:0] d_out0, d_out1;
   logic [15:0] d_out2;

   int n_tests = 0;
   int n_fail  = 0;

   // {instance[1:0], overflow, neg, bcd[19:0]}
   logic [23:0] sb [$];
   logic [23:0] mon_e;
   logic [21:0] bp_exp;

   bin_to_bcd_conv #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_uns (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .d_input(d_in[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .d_out(d_out0), .neg(neg[0]), .overflow(ovf[0]));

   bin_to_bcd_conv #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .d_input(d_in[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .d_out(d_out1), .neg(neg[1]), .overflow(ovf[1]));

   bin_to_bcd_conv #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b0)) u_d4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .d_input(d_in[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .d_out(d_out2), .neg(neg[2]), .overflow(ovf[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] dout_of(input int s);
      case (s)
         0:       return d_out0;
         1:       return d_out1;
         default: return {4'h0, d_out2};
      endcase
   endfunction

   // Reference: plain decimal arithmetic on the magnitude.
   function automatic logic [21:0] model(input int s, input logic [15:0] v);
      int          digits;
      int          m;
      int          lim;
      logic        n;
      logic        o;
      logic [19:0] b;
      digits = (s == 2) ? 4 : 5;
      n      = (s == 1) && v[15];
      m      = n ? (65536 - int'(v)) : int'(v);
      lim    = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      o = (m >= lim);
      b = '0;
      for (int i = 0; i < digits; i++) begin
         b[4*i +: 4] = o ? 4'd9 : 4'(m % 10);
         m = m / 10;
      end
      return {o, n, b};
   endfunction

   // Output monitor: every result handshake pops and compares one entry.
   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < 3; s++) begin
            if (out_valid[s] && out_ready[s]) begin
               if (sb.size() == 0) begin
                  check("unexpected_out_valid", 32'(out_valid[s]), 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check("result_inst", 32'(s), 32'(mon_e[23:22]));
                  check("result", 32'({ovf[s], neg[s], dout_of(s)}), 32'(mon_e[21:0]));
               end
            end
         end
      end
   end

   task automatic accept(input int s, input logic [15:0] v);
      int t = 0;
      in_valid[s] = 1'b1;
      d_in[s]     = v;
      @(negedge clk);
      while (!in_ready[s] && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", 32'(t < 200), 32'd1);
      sb.push_back({2'(s), model(s, v)});
      @(posedge clk);
      #1;
      // Later changes to d_input must not affect the result.
      in_valid[s] = 1'b0;
      d_in[s]     = 16'($urandom);
      check("in_ready_drop", 32'(in_ready[s]), 32'd0);
   endtask

   task automatic wait_result(input int s);
      int lat = 0;
      while (!out_valid[s] && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'd16);
   endtask

   task automatic finish_out(input int s);
      @(posedge clk);
      #1;
      check("idle_in_ready", 32'(in_ready[s]), 32'd1);
      check("idle_out_valid", 32'(out_valid[s]), 32'd0);
   endtask

   task automatic convert(input int s, input logic [15:0] v);
      accept(s, v);
      wait_result(s);
      finish_out(s);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '1;
      for (int s = 0; s < 3; s++) d_in[s] = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         check("rst_in_ready", 32'(in_ready[s]), 32'd1);
         check("rst_out_valid", 32'(out_valid[s]), 32'd0);
         check("rst_d_out", 32'(dout_of(s)), 32'd0);
         check("rst_neg", 32'(neg[s]), 32'd0);
         check("rst_overflow", 32'(ovf[s]), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Unsigned, 5 digits
      convert(0, 16'h0000);
      convert(0, 16'hFFFF);
      convert(0, 16'h3039);
      convert(0, 16'd10000);

      // Signed, 5 digits
      convert(1, 16'hFFFF);
      convert(1, 16'h8000);
      convert(1, 16'h7FFF);
      convert(1, 16'h0005);
      convert(1, 16'hFFD6);

      // Unsigned, 4 digits: overflow boundary
      convert(2, 16'd12345);
      convert(2, 16'd9999);
      convert(2, 16'd10000);
      convert(2, 16'd0);

      // Backpressure: stall 10 cycles in DONE with stray in_valid pulses.
      out_ready[0] = 1'b0;
      accept(0, 16'd54321);
      wait_result(0);
      bp_exp = model(0, 16'd54321);
      for (int i = 0; i < 10; i++) begin
         in_valid[0] = (i % 3 == 0);
         d_in[0]     = 16'($urandom);
         @(posedge clk);
         #1;
         check("bp_d_out", 32'(d_out0), 32'(bp_exp[19:0]));
         check("bp_out_valid", 32'(out_valid[0]), 32'd1);
         check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      end
      // Release and present the next word at once: handshake on the next
      // edge, accept on the one after.
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      d_in[0]      = 16'd777;
      sb.push_back({2'd0, model(0, 16'd777)});
      @(posedge clk);
      #1;
      check("b2b_in_ready_up", 32'(in_ready[0]), 32'd1);
      check("b2b_out_valid_down", 32'(out_valid[0]), 32'd0);
      @(posedge clk);
      #1;
      check("b2b_accepted", 32'(in_ready[0]), 32'd0);
      in_valid[0] = 1'b0;
      d_in[0]     = 16'($urandom);
      wait_result(0);
      finish_out(0);

      // Reset at SHIFT cycle 7 discards the conversion.
      accept(0, 16'h1234);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_in_ready", 32'(in_ready[0]), 32'd1);
      check("abort_out_valid", 32'(out_valid[0]), 32'd0);
      check("abort_d_out", 32'(d_out0), 32'd0);
      check("abort_neg", 32'(neg[0]), 32'd0);
      check("abort_overflow", 32'(ovf[0]), 32'd0);
      void'(sb.pop_back());
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      // Any out_valid pulse here would hit the monitor with an empty queue.
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_result", 32'(out_valid[0]), 32'd0);
      convert(0, 16'd42);

      t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      check("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
